// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter issuing one SRAM FIFO command at a time, with completion ack,
// post-command gap and a watchdog that aborts commands the controller never finishes.
module sram_port_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned GAP_CYC     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       fifo_i_full,
    input  logic       fifo_i_empty,
    input  logic       fifo_o_full,
    input  logic       fifo_o_empty,
    input  logic       sram_done,
    output logic [3:0] cmd,
    output logic [3:0] ack,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       timeout_err,
    output logic [1:0] last_gnt
);

    localparam logic [7:0] WD_LAST  = 8'(TIMEOUT_CYC - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_cmd;
    logic [3:0] r_gnt;
    logic [3:0] r_ack;
    logic       r_busy;
    logic       r_timeout;
    logic [1:0] r_last_gnt;
    logic [7:0] r_wd;
    logic [3:0] r_gap;

    logic [3:0] w_elig;
    logic [1:0] w_idx;
    logic [1:0] w_win;
    logic       w_found;

    assign w_elig = req & {~fifo_i_empty, ~fifo_o_full, ~fifo_o_empty, ~fifo_i_full};

    // Search starts one past the last grant; the first eligible bit found wins.
    always_comb begin
        w_idx   = r_last_gnt;
        w_win   = r_last_gnt;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_idx = r_last_gnt + 2'(i + 1);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cmd      <= '0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_last_gnt <= 2'd3;
            r_wd       <= '0;
            r_gap      <= '0;
        end else begin
            r_ack     <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_cmd      <= 4'b0001 << w_win;
                        r_gnt      <= 4'b0001 << w_win;
                        r_last_gnt <= w_win;
                        r_busy     <= 1'b1;
                        r_wd       <= '0;
                        r_state    <= CMD;
                    end
                end
                CMD: begin
                    // Completion takes priority over a watchdog expiring on the same cycle.
                    if (sram_done) begin
                        r_cmd   <= '0;
                        r_gnt   <= '0;
                        r_ack   <= 4'b0001 << r_last_gnt;
                        r_gap   <= '0;
                        r_state <= GAP;
                    end else if (r_wd >= WD_LAST) begin
                        r_cmd     <= '0;
                        r_gnt     <= '0;
                        r_timeout <= 1'b1;
                        r_gap     <= '0;
                        r_state   <= GAP;
                    end else if (r_wd != '1) begin
                        r_wd <= r_wd + 8'd1;
                    end
                end
                GAP: begin
                    if (r_gap >= GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_gap != '1) begin
                        r_gap <= r_gap + 4'd1;
                    end
                end
                default: begin
                    r_cmd   <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd         = r_cmd;
    assign gnt         = r_gnt;
    assign ack         = r_ack;
    assign busy        = r_busy;
    assign timeout_err = r_timeout;
    assign last_gnt    = r_last_gnt;

endmodule
